// File: rtl/tt_sweep_pkg.sv
// Shared FSM encoding and default sizing for the truth-table sweep controller.
// Optional feature macro used by the controller: TT_SWEEP_STOP_ON_ERR_EN.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } sweep_state_t;

    localparam int N_VARS_DEF = 5;
    localparam int SETTLE_DEF = 1;

endpackage

// File: rtl/tt_err_acc.sv
// Per-implementation mismatch accumulator: one mask bit per input vector
// plus a saturating mismatch count.
module tt_err_acc
    import tt_sweep_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  chk,
    input  logic [N_VARS-1:0]     idx,
    input  logic                  mis,
    output logic [(1<<N_VARS)-1:0] err_mask,
    output logic [N_VARS:0]       err_cnt
);

    localparam int NT = 1 << N_VARS;
    localparam logic [N_VARS:0] CNT_MAX = (N_VARS+1)'(NT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_mask <= '0;
            err_cnt  <= '0;
        end else if (chk) begin
            err_mask[idx] <= mis;
            if (mis && err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweep comparing two implementations to a reference.
// Define TT_SWEEP_STOP_ON_ERR_EN to end the sweep at the first mismatch.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_VARS = N_VARS_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_VARS)-1:0] ref_table,
    output logic [N_VARS-1:0]      dut_in,
    input  logic                   dut_f1,
    input  logic                   dut_f2,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_VARS)-1:0] err_mask1,
    output logic [(1<<N_VARS)-1:0] err_mask2,
    output logic [N_VARS:0]        err_cnt1,
    output logic [N_VARS:0]        err_cnt2,
    output logic                   pass
);

    localparam int NT = 1 << N_VARS;
    localparam logic [N_VARS-1:0] LAST_IDX = '1;
    localparam logic [3:0] SET_LAST = 4'(SETTLE - 1);

    sweep_state_t      state;
    logic [NT-1:0]     ref_q;
    logic [N_VARS-1:0] idx;
    logic [3:0]        settle;
    logic              clr;
    logic              chk;
    logic              ref_bit;
    logic              mis1;
    logic              mis2;
    logic              stop;

    assign clr     = (state == IDLE) && start;
    assign chk     = (state == CHECK);
    assign ref_bit = ref_q[idx];
    assign mis1    = dut_f1 ^ ref_bit;
    assign mis2    = dut_f2 ^ ref_bit;
    assign dut_in  = idx;

`ifdef TT_SWEEP_STOP_ON_ERR_EN
    assign stop = mis1 | mis2;
`else
    assign stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ref_q  <= '0;
            idx    <= '0;
            settle <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ref_q  <= ref_table;
                        idx    <= '0;
                        settle <= '0;
                        pass   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (settle == SET_LAST) begin
                        settle <= '0;
                        state  <= CHECK;
                    end else begin
                        settle <= settle + 4'd1;
                    end
                end
                CHECK: begin
                    // Terminal vector detected explicitly so idx never wraps.
                    if (stop || idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= HOLD;
                    end
                end
                FIN: begin
                    pass  <= (err_cnt1 == '0) && (err_cnt2 == '0);
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    tt_err_acc #(.N_VARS(N_VARS)) u_acc1 (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .chk      (chk),
        .idx      (idx),
        .mis      (mis1),
        .err_mask (err_mask1),
        .err_cnt  (err_cnt1)
    );

    tt_err_acc #(.N_VARS(N_VARS)) u_acc2 (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .chk      (chk),
        .idx      (idx),
        .mis      (mis2),
        .err_mask (err_mask2),
        .err_cnt  (err_cnt2)
    );

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl with a queue of expected sweep results.
// Honours TT_SWEEP_STOP_ON_ERR_EN when computing expectations.
module tb_tt_sweep_ctrl;

    localparam int NV = 5;
    localparam int NT = 32;
    localparam int ST = 1;

    typedef struct {
        logic [31:0] mask1;
        logic [31:0] mask2;
        logic [5:0]  cnt1;
        logic [5:0]  cnt2;
        logic        pass;
        int          lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   ref_table = '0;
    logic [NV-1:0] dut_in;
    logic          dut_f1;
    logic          dut_f2;
    logic          busy;
    logic          done;
    logic [31:0]   err_mask1;
    logic [31:0]   err_mask2;
    logic [NV:0]   err_cnt1;
    logic [NV:0]   err_cnt2;
    logic          pass;

    logic [31:0] t1 = '0;
    logic [31:0] t2 = '0;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    localparam logic [31:0] REF_A = 32'h52263ECD;
    localparam logic [31:0] REF_B = 32'hA5F00F5A;

    always #5 clk = ~clk;

    assign dut_f1 = t1[dut_in];
    assign dut_f2 = t2[dut_in];

    tt_sweep_ctrl #(.N_VARS(NV), .SETTLE(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_table (ref_table),
        .dut_in    (dut_in),
        .dut_f1    (dut_f1),
        .dut_f2    (dut_f2),
        .busy      (busy),
        .done      (done),
        .err_mask1 (err_mask1),
        .err_mask2 (err_mask2),
        .err_cnt1  (err_cnt1),
        .err_cnt2  (err_cnt2),
        .pass      (pass)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] r,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic [31:0] keep;
        int k;
        e.mask1 = a ^ r;
        e.mask2 = b ^ r;
        e.lat = NT * (ST + 1);
        keep = '1;
`ifdef TT_SWEEP_STOP_ON_ERR_EN
        k = -1;
        for (int i = NT - 1; i >= 0; i--) begin
            if (e.mask1[i] || e.mask2[i]) k = i;
        end
        if (k >= 0) begin
            keep = 32'((64'd1 << (k + 1)) - 64'd1);
            e.lat = (k + 1) * (ST + 1);
        end
`else
        k = 0;
`endif
        e.mask1 &= keep;
        e.mask2 &= keep;
        e.cnt1 = 6'($countones(e.mask1));
        e.cnt2 = 6'($countones(e.mask2));
        e.pass = (e.cnt1 == 0) && (e.cnt2 == 0) && (k >= 0 || k < 0);
        return e;
    endfunction

    // Drive one sweep; optional restart attempt with another table at cycle rs.
    task automatic run_sweep(input string tag, input logic [31:0] r,
                             input logic [31:0] a, input logic [31:0] b,
                             input int rs, input logic [31:0] r2);
        exp_t e;
        int cyc;
        sb.push_back(model(r, a, b));
        t1 = a;
        t2 = b;
        @(negedge clk);
        ref_table = r;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (cyc == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
            if (done) break;
            if (cyc == rs) begin
                start = 1'b1;
                ref_table = r2;
            end
        end
        e = sb.pop_front();
        check({tag, "_lat"}, 64'(cyc), 64'(e.lat));
        check({tag, "_busy_fin"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_mask1"}, 64'(err_mask1), 64'(e.mask1));
        check({tag, "_mask2"}, 64'(err_mask2), 64'(e.mask2));
        check({tag, "_cnt1"}, 64'(err_cnt1), 64'(e.cnt1));
        check({tag, "_cnt2"}, 64'(err_cnt2), 64'(e.cnt2));
        check({tag, "_pass"}, 64'(pass), 64'(e.pass));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dut_in"}, 64'(dut_in), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_masks"}, {err_mask1, err_mask2}, 64'd0);
        check({tag, "_cnts"}, 64'({err_cnt1, err_cnt2}), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_sweep("all_ok", REF_A, REF_A, REF_A, -1, '0);
        run_sweep("f1_bit7", REF_A, REF_A ^ 32'h80, REF_A, -1, '0);
        run_sweep("f2_inv", REF_A, REF_A, ~REF_A, -1, '0);

        repeat (5) @(posedge clk);
        #1;
        check("hold_mask2", 64'(err_mask2), 64'hFFFFFFFF);
        check("hold_cnt2", 64'(err_cnt2), 64'd32);

        run_sweep("f1_bit3", REF_A, REF_A ^ 32'h8, REF_A, -1, '0);

        // Abort a sweep with reset at cycle 20.
        t1 = REF_B;
        t2 = ~REF_B;
        @(negedge clk);
        ref_table = REF_B;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("abort");
        dones = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        run_sweep("after_abort", REF_B, REF_B, REF_B ^ 32'h8000_0001, -1, '0);
        run_sweep("restart_ign", REF_A, REF_A ^ 32'h0001_0000, REF_A, 10, REF_B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
